// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Runs one memory read or write through the MAR/MDR pair. The controller
// issues a one-cycle start pulse. The block then drives the MAR/MDR gate
// strobes, performs a req/ack handshake with memory and aborts the access
// if the memory stalls for too long.
//
// Ports
//   CLK       in   system clock, rising edge
//   CLR       in   asynchronous active-low reset
//   start_rd  in   read request pulse (sampled in IDLE only)
//   start_wr  in   write request pulse (sampled in IDLE only, read wins)
//   mem_ack   in   memory completion (sampled in REQ only)
//   SMA       out  S bus -> MAR strobe (ADDR)
//   SMD       out  S bus -> MDR strobe (WDATA)
//   MMD       out  M bus -> MDR strobe (CAPT)
//   MDM       out  MDR -> M bus drive (REQ of a write)
//   mem_req   out  memory request (REQ)
//   mem_we    out  write qualifier (REQ of a write)
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//   err       out  one-cycle timeout pulse
//
// TIMEOUT: REQ cycles allowed without mem_ack, legal range 1..255.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic CLR,
  input  logic start_rd,
  input  logic start_wr,
  input  logic mem_ack,
  output logic SMA,
  output logic SMD,
  output logic MMD,
  output logic MDM,
  output logic mem_req,
  output logic mem_we,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned StateW = 3;
  localparam int unsigned CntW   = 8;

  localparam logic [StateW-1:0] S_IDLE  = 3'd0;
  localparam logic [StateW-1:0] S_ADDR  = 3'd1;
  localparam logic [StateW-1:0] S_WDATA = 3'd2;
  localparam logic [StateW-1:0] S_REQ   = 3'd3;
  localparam logic [StateW-1:0] S_CAPT  = 3'd4;
  localparam logic [StateW-1:0] S_DONE  = 3'd5;
  localparam logic [StateW-1:0] S_ERR   = 3'd6;

  // Last counter value before the wait budget is exhausted.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [StateW-1:0] state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [CntW-1:0]   cnt_q,   cnt_d;

  logic sma_q,  sma_d;
  logic smd_q,  smd_d;
  logic mmd_q,  mmd_d;
  logic mdm_q,  mdm_d;
  logic req_q,  req_d;
  logic we_q,   we_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q,  err_d;

  // Next state, access type and wait counter.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        // Read takes priority when both starts arrive together.
        if (start_rd) begin
          is_wr_d = 1'b0;
          state_d = S_ADDR;
        end else if (start_wr) begin
          is_wr_d = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = is_wr_q ? S_WDATA : S_REQ;
      end
      S_WDATA: begin
        cnt_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        // An ack on the final allowed edge still completes the access.
        if (mem_ack) begin
          state_d = is_wr_q ? S_DONE : S_CAPT;
        end else if (cnt_q == CntLast) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_CAPT:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered so outputs line up with state.
  always_comb begin
    sma_d  = 1'b0;
    smd_d  = 1'b0;
    mmd_d  = 1'b0;
    mdm_d  = 1'b0;
    req_d  = 1'b0;
    we_d   = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    err_d  = 1'b0;

    case (state_d)
      S_ADDR:  sma_d = 1'b1;
      S_WDATA: smd_d = 1'b1;
      S_REQ: begin
        req_d = 1'b1;
        we_d  = is_wr_d;
        mdm_d = is_wr_d;
      end
      S_CAPT:  mmd_d  = 1'b1;
      S_DONE:  done_d = 1'b1;
      S_ERR:   err_d  = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      sma_q   <= 1'b0;
      smd_q   <= 1'b0;
      mmd_q   <= 1'b0;
      mdm_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      sma_q   <= sma_d;
      smd_q   <= smd_d;
      mmd_q   <= mmd_d;
      mdm_q   <= mdm_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign SMA     = sma_q;
  assign SMD     = smd_q;
  assign MMD     = mmd_q;
  assign MDM     = mdm_q;
  assign mem_req = req_q;
  assign mem_we  = we_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed, table-driven bench for mem_access_sequencer. Three instances:
// TIMEOUT=4 (main sequences), TIMEOUT=2 (short timeout edges), default 255.
module tb_mem_access_sequencer;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  logic rd [3];
  logic wr [3];
  logic ack [3];
  logic sma [3];
  logic smd [3];
  logic mmd [3];
  logic mdm [3];
  logic req [3];
  logic we [3];
  logic busy [3];
  logic done [3];
  logic err [3];

  mem_access_sequencer #(.TIMEOUT(4)) u_dut0 (
    .CLK(CLK), .CLR(CLR), .start_rd(rd[0]), .start_wr(wr[0]), .mem_ack(ack[0]),
    .SMA(sma[0]), .SMD(smd[0]), .MMD(mmd[0]), .MDM(mdm[0]), .mem_req(req[0]),
    .mem_we(we[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

  mem_access_sequencer #(.TIMEOUT(2)) u_dut1 (
    .CLK(CLK), .CLR(CLR), .start_rd(rd[1]), .start_wr(wr[1]), .mem_ack(ack[1]),
    .SMA(sma[1]), .SMD(smd[1]), .MMD(mmd[1]), .MDM(mdm[1]), .mem_req(req[1]),
    .mem_we(we[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

  mem_access_sequencer u_dut2 (
    .CLK(CLK), .CLR(CLR), .start_rd(rd[2]), .start_wr(wr[2]), .mem_ack(ack[2]),
    .SMA(sma[2]), .SMD(smd[2]), .MMD(mmd[2]), .MDM(mdm[2]), .mem_req(req[2]),
    .mem_we(we[2]), .busy(busy[2]), .done(done[2]), .err(err[2]));

  // Output vector order: {SMA,SMD,MMD,MDM,mem_req,mem_we,busy,done,err}
  localparam logic [8:0] O_IDLE  = 9'b000000000;
  localparam logic [8:0] O_ADDR  = 9'b100000100;
  localparam logic [8:0] O_WDATA = 9'b010000100;
  localparam logic [8:0] O_RREQ  = 9'b000010100;
  localparam logic [8:0] O_WREQ  = 9'b000111100;
  localparam logic [8:0] O_CAPT  = 9'b001000100;
  localparam logic [8:0] O_DONE  = 9'b000000110;
  localparam logic [8:0] O_ERR   = 9'b000000101;

  // MDR stand-in for instance 0: latches memory data while MMD is high.
  logic [15:0] mem_dat = 16'h0000;
  logic [15:0] mdr     = 16'hDEAD;
  always @(posedge CLK) if (mmd[0]) mdr <= mem_dat;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ack;
    logic [15:0] dat;
    logic [8:0]  exp;
    logic [15:0] mdr;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [8:0] outs(input int i);
    return {sma[i], smd[i], mmd[i], mdm[i], req[i], we[i], busy[i], done[i], err[i]};
  endfunction

  task automatic add(input logic a_rd, input logic a_wr, input logic a_ack,
                     input logic [15:0] a_dat, input logic [8:0] a_exp,
                     input logic [15:0] a_mdr);
    vec_t v;
    v.rd = a_rd; v.wr = a_wr; v.ack = a_ack;
    v.dat = a_dat; v.exp = a_exp; v.mdr = a_mdr;
    tbl.push_back(v);
  endtask

  // Row r: outputs expected in cycle r, inputs applied during cycle r.
  task automatic run_tbl(input int inst, input string name);
    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge CLK); #1;
      checks++;
      if (outs(inst) !== tbl[r].exp) begin
        failures++;
        $display("FAIL %s row %0d outputs got %b want %b", name, r, outs(inst), tbl[r].exp);
      end
      if (inst == 0) begin
        checks++;
        if (mdr !== tbl[r].mdr) begin
          failures++;
          $display("FAIL %s row %0d mdr got %h want %h", name, r, mdr, tbl[r].mdr);
        end
      end
      rd[inst]  = tbl[r].rd;
      wr[inst]  = tbl[r].wr;
      ack[inst] = tbl[r].ack;
      mem_dat   = tbl[r].dat;
    end
    tbl.delete();
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got %b want %b", name, act, expv);
    end
  endtask

  initial begin
    int err_at;
    int req_cnt;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ack[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_inst%0d", i), outs(i), O_IDLE);
    @(negedge CLK);
    CLR = 1'b1;

    // Instance 0: read, back-to-back write with delayed ack (ack on the
    // timeout edge), read timeout, simultaneous starts.
    add(1,0,1,16'h1234,O_IDLE ,16'hDEAD);
    add(0,0,1,16'h1234,O_ADDR ,16'hDEAD);
    add(0,0,1,16'h1234,O_RREQ ,16'hDEAD);
    add(0,0,1,16'h1234,O_CAPT ,16'hDEAD);
    add(0,1,0,16'h1234,O_DONE ,16'h1234);
    add(0,1,0,16'h1234,O_IDLE ,16'h1234);
    add(0,0,0,16'h1234,O_ADDR ,16'h1234);
    add(0,0,0,16'h1234,O_WDATA,16'h1234);
    add(0,0,0,16'h1234,O_WREQ ,16'h1234);
    add(0,0,0,16'h1234,O_WREQ ,16'h1234);
    add(0,0,0,16'h1234,O_WREQ ,16'h1234);
    add(0,0,1,16'h1234,O_WREQ ,16'h1234);
    add(0,0,0,16'h5555,O_DONE ,16'h1234);
    add(1,0,0,16'h5555,O_IDLE ,16'h1234);
    add(0,0,0,16'h5555,O_ADDR ,16'h1234);
    add(0,0,0,16'h5555,O_RREQ ,16'h1234);
    add(0,0,0,16'h5555,O_RREQ ,16'h1234);
    add(0,0,0,16'h5555,O_RREQ ,16'h1234);
    add(0,0,0,16'h5555,O_RREQ ,16'h1234);
    add(0,0,0,16'h5555,O_ERR  ,16'h1234);
    add(1,1,1,16'hBEEF,O_IDLE ,16'h1234);
    add(0,0,1,16'hBEEF,O_ADDR ,16'h1234);
    add(0,1,1,16'hBEEF,O_RREQ ,16'h1234);
    add(0,0,1,16'hBEEF,O_CAPT ,16'h1234);
    add(0,0,1,16'hBEEF,O_DONE ,16'hBEEF);
    add(0,0,1,16'hBEEF,O_IDLE ,16'hBEEF);
    add(0,0,0,16'hBEEF,O_IDLE ,16'hBEEF);
    run_tbl(0, "seq_main");

    // Instance 0: asynchronous reset during REQ of a write
    @(posedge CLK); #1;
    wr[0] = 1'b1;
    @(posedge CLK); #1;
    wr[0] = 1'b0;
    chk("clr_pre_addr", outs(0), O_ADDR);
    @(posedge CLK); #1;
    chk("clr_pre_wdata", outs(0), O_WDATA);
    @(posedge CLK); #1;
    chk("clr_pre_req", outs(0), O_WREQ);
    #2 CLR = 1'b0;
    #1 chk("clr_async_drop", outs(0), O_IDLE);
    @(negedge CLK);
    CLR = 1'b1;

    // Read after reset release: standard 4-cycle latency
    add(1,0,1,16'hA5A5,O_IDLE,16'hBEEF);
    add(0,0,1,16'hA5A5,O_ADDR,16'hBEEF);
    add(0,0,1,16'hA5A5,O_RREQ,16'hBEEF);
    add(0,0,1,16'hA5A5,O_CAPT,16'hBEEF);
    add(0,0,0,16'hA5A5,O_DONE,16'hA5A5);
    add(0,0,0,16'hA5A5,O_IDLE,16'hA5A5);
    run_tbl(0, "seq_post_clr");

    // Instance 1 (TIMEOUT=2): read timeout, write timeout, ack on timeout edge
    add(1,0,0,16'h0,O_IDLE,16'h0);
    add(0,0,0,16'h0,O_ADDR,16'h0);
    add(0,0,0,16'h0,O_RREQ,16'h0);
    add(0,0,0,16'h0,O_RREQ,16'h0);
    add(0,0,0,16'h0,O_ERR ,16'h0);
    add(0,1,0,16'h0,O_IDLE,16'h0);
    add(0,0,0,16'h0,O_ADDR ,16'h0);
    add(0,0,0,16'h0,O_WDATA,16'h0);
    add(0,0,0,16'h0,O_WREQ ,16'h0);
    add(0,0,0,16'h0,O_WREQ ,16'h0);
    add(0,0,0,16'h0,O_ERR  ,16'h0);
    add(1,0,0,16'h0,O_IDLE ,16'h0);
    add(0,0,0,16'h0,O_ADDR,16'h0);
    add(0,0,0,16'h0,O_RREQ,16'h0);
    add(0,0,1,16'h0,O_RREQ,16'h0);
    add(0,0,0,16'h0,O_CAPT,16'h0);
    add(0,0,0,16'h0,O_DONE,16'h0);
    add(0,0,0,16'h0,O_IDLE,16'h0);
    run_tbl(1, "seq_to2");

    // Instance 2 (default TIMEOUT=255): stalled read errors at n+257
    @(posedge CLK); #1;
    rd[2]   = 1'b1;
    err_at  = -1;
    req_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge CLK); #1;
      if (k == 1) rd[2] = 1'b0;
      if (req[2]) req_cnt++;
      if (err[2] && err_at < 0) err_at = k;
    end
    checks++;
    if (err_at != 257) begin
      failures++;
      $display("FAIL to255_err_cycle got %0d want 257", err_at);
    end
    checks++;
    if (req_cnt != 255) begin
      failures++;
      $display("FAIL to255_req_cycles got %0d want 255", req_cnt);
    end
    chk("to255_idle_after", outs(2), O_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
